mux32_arbiter: RTL

//  Two-requester arbiter that shares one _mux32-fed 32-bit resource (e.g. memory bus:

---
 rtl/mux32_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/mux32_arbiter.sv
// Two-requester round-robin arbiter for a shared _mux32-fed 32-bit resource.
// Drives mux select and active-low enable, with a dead turnaround and a hold timeout.
module mux32_arbiter #(
  parameter int MAX_HOLD    = 16,
  parameter int HOLD_W      = 5,
  parameter int TURN_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic req_a,
  input  logic req_b,
  input  logic done,
  output logic gnt_a,
  output logic gnt_b,
  output logic sel,
  output logic mux_en_n,
  output logic busy,
  output logic timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2,
    TURN  = 2'd3
  } state_t;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  localparam logic [1:0]        TURN_LAST = 2'(TURN_CYCLES - 1);

  state_t            state_q, state_d, arb_state;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [1:0]        turn_cnt_q, turn_cnt_d;
  logic              last_q, last_d;       // 0 = A owned last, 1 = B owned last
  logic              own_req;

  logic gnt_a_q, gnt_a_d;
  logic gnt_b_q, gnt_b_d;
  logic sel_q, sel_d;
  logic mux_en_n_q, mux_en_n_d;
  logic busy_q, busy_d;
  logic timeout_q, timeout_d;

  // Arbitration decision shared by IDLE and the final TURN cycle.
  always_comb begin
    arb_state = IDLE;
    if (req_a && !req_b) begin
      arb_state = OWN_A;
    end else if (req_b && !req_a) begin
      arb_state = OWN_B;
    end else if (req_a && req_b) begin
      arb_state = last_q ? OWN_A : OWN_B;
    end
  end

  assign own_req = (state_q == OWN_A) ? req_a : req_b;

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = '0;
    turn_cnt_d = turn_cnt_q;
    last_d     = last_q;
    timeout_d  = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = arb_state;
      end
      OWN_A, OWN_B: begin
        if (done || !own_req || (hold_cnt_q == HOLD_LAST)) begin
          state_d    = TURN;
          turn_cnt_d = '0;
          last_d     = (state_q == OWN_B);
          // done and a dropped request both take precedence over expiry
          timeout_d  = !done && own_req;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      TURN: begin
        if (turn_cnt_q == TURN_LAST) begin
          state_d = arb_state;
        end else begin
          turn_cnt_d = turn_cnt_q + 2'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state; sel only moves on entry to an owner.
  always_comb begin
    gnt_a_d    = (state_d == OWN_A);
    gnt_b_d    = (state_d == OWN_B);
    mux_en_n_d = !(gnt_a_d || gnt_b_d);
    busy_d     = (state_d != IDLE);
    sel_d      = sel_q;
    if (gnt_b_d) begin
      sel_d = 1'b1;
    end else if (gnt_a_d) begin
      sel_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      hold_cnt_q <= '0;
      turn_cnt_q <= '0;
      last_q     <= 1'b1;
      gnt_a_q    <= 1'b0;
      gnt_b_q    <= 1'b0;
      sel_q      <= 1'b0;
      mux_en_n_q <= 1'b1;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      turn_cnt_q <= turn_cnt_d;
      last_q     <= last_d;
      gnt_a_q    <= gnt_a_d;
      gnt_b_q    <= gnt_b_d;
      sel_q      <= sel_d;
      mux_en_n_q <= mux_en_n_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
    end
  end

  assign gnt_a    = gnt_a_q;
  assign gnt_b    = gnt_b_q;
  assign sel      = sel_q;
  assign mux_en_n = mux_en_n_q;
  assign busy     = busy_q;
  assign timeout  = timeout_q;

endmodule
